// File: rtl/ni_flit_ejector_if.sv
// Flit-in / packet-out bundle between the router LOCAL port, the ejector and its consumer.
// The slave modport is the ejector; the master modport is the router/consumer side.
`ifndef VC_PER_PORT
`define VC_PER_PORT 4
`endif

interface ni_flit_ejector_if #(
  parameter int unsigned VC_NUM    = `VC_PER_PORT,
  parameter int unsigned MAX_FLITS = 4,
  parameter int unsigned PAYLOAD_W = 64
);
  localparam int unsigned VcW  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned LenW = $clog2(MAX_FLITS) + 1;

  logic                          router_flit_in_valid;
  logic [1:0]                    router_flit_in_type;
  logic [VcW-1:0]                router_flit_in_vc;
  logic [PAYLOAD_W-1:0]          router_flit_in_payload;
  logic [VC_NUM-1:0]             ni_credit;
  logic                          pkt_valid;
  logic [VcW-1:0]                pkt_vc;
  logic [LenW-1:0]               pkt_len;
  logic [MAX_FLITS*PAYLOAD_W-1:0] pkt_data;
  logic                          pkt_consumed;
  logic                          protocol_error;

  modport slave (
    input  router_flit_in_valid, router_flit_in_type, router_flit_in_vc,
    input  router_flit_in_payload, pkt_consumed,
    output ni_credit, pkt_valid, pkt_vc, pkt_len, pkt_data, protocol_error
  );

  modport master (
    output router_flit_in_valid, router_flit_in_type, router_flit_in_vc,
    output router_flit_in_payload, pkt_consumed,
    input  ni_credit, pkt_valid, pkt_vc, pkt_len, pkt_data, protocol_error
  );
endinterface

// File: rtl/ni_flit_ejector.sv
// Router LOCAL-port ejector: per-VC packet reassembly, on-off backpressure and
// round-robin presentation of completed packets to a single consumer.
`ifndef VC_PER_PORT
`define VC_PER_PORT 4
`endif

module ni_flit_ejector #(
  parameter int unsigned VC_NUM    = `VC_PER_PORT,
  parameter int unsigned MAX_FLITS = 4,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned OFF_SLACK = 1
) (
  input logic           clk,
  input logic           reset,
  input logic           enable,
  ni_flit_ejector_if.slave bus
);
  localparam int unsigned VcW  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned LenW = $clog2(MAX_FLITS) + 1;
  localparam int unsigned BufW = MAX_FLITS * PAYLOAD_W;

  localparam logic [1:0] FlitHead = 2'd0;
  localparam logic [1:0] FlitBody = 2'd1;
  localparam logic [1:0] FlitTail = 2'd2;
  localparam logic [1:0] FlitHt   = 2'd3;

  typedef enum logic [1:0] {StIdle, StCollect, StComplete} vc_state_e;

  vc_state_e         state_q [VC_NUM];
  vc_state_e         state_d [VC_NUM];
  logic [LenW-1:0]   count_q [VC_NUM];
  logic [LenW-1:0]   count_d [VC_NUM];
  logic [BufW-1:0]   buf_q   [VC_NUM];
  logic [BufW-1:0]   buf_d   [VC_NUM];
  logic [VC_NUM-1:0] credit_q, credit_d;
  logic              err_q, err_d;
  logic [VcW-1:0]    ptr_q;
  logic              pkt_valid_q;
  logic [VcW-1:0]    pkt_vc_q;
  logic [LenW-1:0]   pkt_len_q;
  logic [BufW-1:0]   pkt_data_q;

  logic              win_found;
  logic [VcW-1:0]    win_vc, cand, fv;
  logic              latch;

  // Round-robin search over COMPLETE VCs, starting at the pointer.
  always_comb begin
    win_found = 1'b0;
    win_vc    = '0;
    cand      = '0;
    for (int i = 0; i < int'(VC_NUM); i++) begin
      cand = VcW'((32'(ptr_q) + 32'(i)) % VC_NUM);
      if (!win_found && state_q[cand] == StComplete) begin
        win_found = 1'b1;
        win_vc    = cand;
      end
    end
  end

  assign latch = enable && win_found && (!pkt_valid_q || bus.pkt_consumed);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    buf_d   = buf_q;
    err_d   = err_q;
    fv      = bus.router_flit_in_vc;
    // The latched VC is freed first so a flit on it this cycle sees IDLE.
    if (latch) begin
      state_d[win_vc] = StIdle;
      count_d[win_vc] = '0;
      buf_d[win_vc]   = '0;
    end
    if (enable && bus.router_flit_in_valid) begin
      unique case (state_d[fv])
        StIdle: begin
          if (bus.router_flit_in_type == FlitHead || bus.router_flit_in_type == FlitHt) begin
            buf_d[fv][0 +: PAYLOAD_W] = bus.router_flit_in_payload;
            count_d[fv] = LenW'(1);
            state_d[fv] = (bus.router_flit_in_type == FlitHt) ? StComplete : StCollect;
          end else begin
            err_d = 1'b1;
          end
        end
        StCollect: begin
          if ((bus.router_flit_in_type == FlitBody || bus.router_flit_in_type == FlitTail) &&
              count_d[fv] < LenW'(MAX_FLITS)) begin
            buf_d[fv][32'(count_d[fv]) * PAYLOAD_W +: PAYLOAD_W] = bus.router_flit_in_payload;
            count_d[fv] = count_d[fv] + LenW'(1);
            if (bus.router_flit_in_type == FlitTail) state_d[fv] = StComplete;
          end else begin
            err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      credit_d[v] = (count_d[v] >= LenW'(MAX_FLITS - OFF_SLACK)) || (state_d[v] == StComplete);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        state_q[v] <= StIdle;
        count_q[v] <= '0;
        buf_q[v]   <= '0;
      end
      credit_q    <= '0;
      err_q       <= 1'b0;
      ptr_q       <= '0;
      pkt_valid_q <= 1'b0;
      pkt_vc_q    <= '0;
      pkt_len_q   <= '0;
      pkt_data_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      buf_q    <= buf_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      if (latch) begin
        pkt_valid_q <= 1'b1;
        pkt_vc_q    <= win_vc;
        pkt_len_q   <= count_q[win_vc];
        pkt_data_q  <= buf_q[win_vc];
        ptr_q       <= (win_vc == VcW'(VC_NUM - 1)) ? '0 : win_vc + VcW'(1);
      end else if (enable && bus.pkt_consumed) begin
        pkt_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ni_credit      = credit_q;
  assign bus.pkt_valid      = pkt_valid_q;
  assign bus.pkt_vc         = pkt_vc_q;
  assign bus.pkt_len        = pkt_len_q;
  assign bus.pkt_data       = pkt_data_q;
  assign bus.protocol_error = err_q;
endmodule
